// File: rtl/mod_n_counter_pkg.sv
// Shared constants and types for the modulo-N up/down counter.
package mod_n_counter_pkg;
  localparam int N_DEF     = 10;
  localparam int WIDTH_DEF = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [WIDTH_DEF-1:0] count_t;
endpackage

// File: rtl/mod_n_counter_if.sv
// Direction/count bundle of the modulo-N counter; TC exists only when MODN_TC_EN is defined.
interface mod_n_counter_if
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             UPORDOWN;
  logic [WIDTH-1:0] COUNT;
`ifdef MODN_TC_EN
  logic             TC;

  modport slv (input UPORDOWN, output COUNT, output TC);
  modport mst (output UPORDOWN, input COUNT, input TC);
`else
  modport slv (input UPORDOWN, output COUNT);
  modport mst (output UPORDOWN, input COUNT);
`endif
endinterface

// File: rtl/mod_n_counter_next_count.sv
// Combinational next-count: wrap in both directions, and recovery from out-of-range counts.
module mod_n_next_count
  import mod_n_counter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next
);
  // One spare bit so N-1 == 2**WIDTH-1 and the +1 step cannot overflow silently.
  logic [WIDTH:0] w_cnt;
  logic [WIDTH:0] w_last;
  logic [WIDTH:0] w_sum;

  assign w_cnt  = {1'b0, i_count};
  assign w_last = (WIDTH+1)'(N - 1);

  always_comb begin
    w_sum = '0;
    if (w_cnt > w_last)
      w_sum = '0;
    else if (i_up == DIR_UP)
      w_sum = (w_cnt == w_last) ? '0 : w_cnt + (WIDTH+1)'(1);
    else
      w_sum = (w_cnt == '0) ? w_last : w_cnt - (WIDTH+1)'(1);
  end

  assign o_next = WIDTH'(w_sum);
endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with registered COUNT; optional registered TC flag under MODN_TC_EN.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mod_n_counter_if.slv bus
);
  if (N < 2 || N > (1 << WIDTH)) begin : g_bad_n
    $error("mod_n_counter: N=%0d illegal for WIDTH=%0d", N, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  mod_n_next_count #(.N(N), .WIDTH(WIDTH)) u_next (
    .i_count (r_count),
    .i_up    (bus.UPORDOWN),
    .o_next  (w_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_count <= '0;
    else        r_count <= w_next;
  end

  assign bus.COUNT = r_count;

`ifdef MODN_TC_EN
  // Flag is computed from the value being loaded, so it lines up with COUNT in the same cycle.
  logic r_tc;

  always_ff @(posedge clk) begin
    if (!reset)
      r_tc <= 1'b0;
    else
      r_tc <= (bus.UPORDOWN == DIR_UP)   ? (w_next == LAST)
                                         : (w_next == '0);
  end

  assign bus.TC = r_tc;
`endif
endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter (N=10 and N=16, WIDTH=4); TC checked when MODN_TC_EN is defined.
module tb_mod_n_counter;
  import mod_n_counter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mod_n_counter_if #(.WIDTH(4)) bus10 ();
  mod_n_counter_if #(.WIDTH(4)) bus16 ();

  mod_n_counter #(.N(10), .WIDTH(4)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
  mod_n_counter #(.N(16), .WIDTH(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

`ifdef MODN_TC_EN
  task automatic chk_tc(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: TC got %b expected %b", tag, got, exp);
    end
  endtask
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp_dn [11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
  int exp_sw [4]  = '{6, 5, 4, 3};

  initial begin
    bus10.UPORDOWN = DIR_UP;
    bus16.UPORDOWN = DIR_UP;

    // Three edges in reset, count must sit at 0
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst[%0d]", i), bus10.COUNT, 4'd0);
`ifdef MODN_TC_EN
      chk_tc($sformatf("rst_tc[%0d]", i), bus10.TC, 1'b0);
`endif
    end

    // Up from release, wrap 9 -> 0
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("up[%0d]", i), bus10.COUNT, 4'(exp_up[i]));
`ifdef MODN_TC_EN
      chk_tc($sformatf("up_tc[%0d]", i), bus10.TC, exp_up[i] == 9);
`endif
    end

    // Down from release, wrap 0 -> 9
    reset = 1'b0;
    bus10.UPORDOWN = DIR_DOWN;
    tick();
    chk("rst_dn", bus10.COUNT, 4'd0);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("dn[%0d]", i), bus10.COUNT, 4'(exp_dn[i]));
`ifdef MODN_TC_EN
      chk_tc($sformatf("dn_tc[%0d]", i), bus10.TC, exp_dn[i] == 0);
`endif
    end

    // Up to 5, then reverse one edge later
    reset = 1'b0;
    bus10.UPORDOWN = DIR_UP;
    tick();
    chk("rst_sw", bus10.COUNT, 4'd0);
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sw_up[%0d]", i), bus10.COUNT, 4'(i));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sw[%0d]", i), bus10.COUNT, 4'(exp_sw[i]));
      bus10.UPORDOWN = DIR_DOWN;
    end

    // From 3 up to 7, reset mid-count overrides direction, then release
    bus10.UPORDOWN = DIR_UP;
    for (int i = 4; i <= 7; i++) begin
      tick();
      chk($sformatf("pre_abort[%0d]", i), bus10.COUNT, 4'(i));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus10.UPORDOWN = i[0] ? DIR_DOWN : DIR_UP;
      tick();
      chk($sformatf("abort[%0d]", i), bus10.COUNT, 4'd0);
`ifdef MODN_TC_EN
      chk_tc($sformatf("abort_tc[%0d]", i), bus10.TC, 1'b0);
`endif
    end
    bus10.UPORDOWN = DIR_UP;
    reset = 1'b1;
    tick();
    chk("abort_rel", bus10.COUNT, 4'd1);

    // N = 2**WIDTH: full 0..15 then wrap
    reset = 1'b0;
    tick();
    chk("n16_rst", bus16.COUNT, 4'd0);
    reset = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk($sformatf("n16[%0d]", i), bus16.COUNT, 4'(i % 16));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
